// File: rtl/cpu6_dmem_resp.sv
// Memory-side responder for the MEM-stage data port: one word access per request, fixed LATENCY.
// Define CPU6_DMEM_ERRCHK_EN to fault misaligned and out-of-range requests via resp_err.
module cpu6_dmem_resp #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state_reg;
   logic [3:0]    cnt_reg;
   logic          write_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wdata_reg;
   logic [3:0]    wstrb_reg;
   logic          resp_valid_reg;
   logic          rdata_en_reg;
   logic          err_reg;

   logic          acc_go;
   logic          acc_write;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [3:0]    acc_wstrb;
   logic [AW-1:0] acc_idx;
   logic          fault;
   logic [31:0]   rd_word;

   // With LATENCY=1 the array is accessed on the accept edge itself, before the
   // holding registers are loaded, so the request inputs feed the array directly.
   always_comb begin
      acc_go    = 1'b0;
      acc_write = write_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      acc_wstrb = wstrb_reg;
      if (LATENCY == 1) begin
         acc_go    = (state_reg == IDLE) && req_valid;
         acc_write = req_write;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_wstrb = req_wstrb;
      end else begin
         acc_go = (state_reg == WAIT) && (cnt_reg == 4'd1);
      end
      if (reset) begin
         acc_go = 1'b0;
      end
   end

   assign acc_idx = acc_addr[AW+1:2];

`ifdef CPU6_DMEM_ERRCHK_EN
   localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
   assign fault    = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
   assign resp_err = err_reg;
`else
   logic unused_bits;
   assign fault       = 1'b0;
   assign resp_err    = 1'b0;
   assign unused_bits = ^{acc_addr[31:AW+2], acc_addr[1:0], err_reg};
`endif

   // One byte-wide array per lane keeps byte-enabled writes RAM-inferable.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] lane_rd_reg;

         always_ff @(posedge clk) begin
            if (acc_go) begin
               if (acc_write && !fault && acc_wstrb[gi]) begin
                  lane_mem[acc_idx] <= acc_wdata[gi*8 +: 8];
               end
               lane_rd_reg <= lane_mem[acc_idx];
            end
         end

         assign rd_word[gi*8 +: 8] = lane_rd_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         write_reg      <= 1'b0;
         addr_reg       <= 32'd0;
         wdata_reg      <= 32'd0;
         wstrb_reg      <= 4'd0;
         resp_valid_reg <= 1'b0;
         rdata_en_reg   <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         resp_valid_reg <= 1'b0;
         rdata_en_reg   <= 1'b0;
         err_reg        <= 1'b0;
         if (acc_go) begin
            resp_valid_reg <= 1'b1;
            err_reg        <= fault;
            rdata_en_reg   <= !acc_write && !fault;
         end
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  write_reg <= req_write;
                  addr_reg  <= req_addr;
                  wdata_reg <= req_wdata;
                  wstrb_reg <= req_wstrb;
                  cnt_reg   <= 4'(LATENCY - 1);
                  state_reg <= (LATENCY == 1) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) begin
                  state_reg <= RESP;
               end
            end
            RESP: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_ready  = (state_reg == IDLE);
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = rdata_en_reg ? rd_word : 32'd0;

endmodule

// File: tb/tb_cpu6_dmem_resp.sv
// Bench for cpu6_dmem_resp: instance 0 runs LATENCY=2, instance 1 runs LATENCY=1,
// both checked every cycle against a request-level model.
module tb_cpu6_dmem_resp;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   logic        rst [2];
   logic        rv  [2];
   logic        rdy [2];
   logic        rw  [2];
   logic [31:0] ra  [2];
   logic [31:0] rd  [2];
   logic [3:0]  rs  [2];
   logic        vld [2];
   logic [31:0] rdat[2];
   logic        err [2];

   cpu6_dmem_resp #(.DEPTH(DEPTH), .LATENCY(2)) u_dut0 (
      .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rdy[0]),
      .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rd[0]), .req_wstrb(rs[0]),
      .resp_valid(vld[0]), .resp_rdata(rdat[0]), .resp_err(err[0])
   );

   cpu6_dmem_resp #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rdy[1]),
      .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rd[1]), .req_wstrb(rs[1]),
      .resp_valid(vld[1]), .resp_rdata(rdat[1]), .resp_err(err[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- request-level model ----------------
   int          lat_of [2] = '{2, 1};
   bit          pend   [2];
   int          due    [2];
   int          free_at[2];
   bit          p_wr   [2];
   logic [31:0] p_addr [2];
   logic [31:0] p_wdata[2];
   logic [3:0]  p_strb [2];
   logic [31:0] mm [int];

   function automatic void model_resp(input int n, output logic [31:0] r, output logic e);
      logic [31:0] a;
      logic [31:0] w;
      int key;
      a = p_addr[n];
`ifdef CPU6_DMEM_ERRCHK_EN
      e = (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
      e = 1'b0;
`endif
      key = n * DEPTH + int'((a >> 2) % DEPTH);
      w = mm.exists(key) ? mm[key] : 32'h0;
      r = 32'h0;
      if (!e) begin
         if (p_wr[n]) begin
            for (int b = 0; b < 4; b++)
               if (p_strb[n][b]) w[b*8 +: 8] = p_wdata[n][b*8 +: 8];
            mm[key] = w;
         end else begin
            r = w;
         end
      end
   endfunction

   always @(negedge clk) begin
      logic        ev;
      logic        ee;
      logic [31:0] er;
      if (cyc > 0) begin
         for (int n = 0; n < 2; n++) begin
            ev = 1'b0;
            ee = 1'b0;
            er = 32'h0;
            if (pend[n] && due[n] == cyc) begin
               ev = 1'b1;
               model_resp(n, er, ee);
               pend[n] = 1'b0;
            end
            check($sformatf("u%0d c%0d req_ready", n, cyc), rdy[n], (cyc >= free_at[n]));
            check($sformatf("u%0d c%0d resp_valid", n, cyc), vld[n], ev);
            check($sformatf("u%0d c%0d resp_rdata", n, cyc), rdat[n], er);
            if (ev) check($sformatf("u%0d c%0d resp_err", n, cyc), err[n], ee);
            if (rst[n]) begin
               pend[n]    = 1'b0;
               free_at[n] = cyc + 1;
            end else if (rv[n] && cyc >= free_at[n]) begin
               pend[n]    = 1'b1;
               due[n]     = cyc + lat_of[n];
               free_at[n] = cyc + lat_of[n] + 1;
               p_wr[n]    = rw[n];
               p_addr[n]  = ra[n];
               p_wdata[n] = rd[n];
               p_strb[n]  = rs[n];
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_req(input int n, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic e, output int lat);
      int acc;
      bit got;
      rv[n] = 1'b1; rw[n] = wr; ra[n] = a; rd[n] = d; rs[n] = s;
      acc = -1;
      for (int k = 0; k < 40 && acc < 0; k++) begin
         @(negedge clk);
         if (rdy[n]) acc = cyc;
      end
      if (acc < 0) check($sformatf("u%0d accept timeout", n), rdy[n], 1'b1);
      @(posedge clk); #1;
      rv[n] = 1'b0; rw[n] = 1'b0; ra[n] = 32'h0; rd[n] = 32'h0; rs[n] = 4'h0;
      got = 1'b0; r = 32'h0; e = 1'b0; lat = -1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (vld[n]) begin
            got = 1'b1; r = rdat[n]; e = err[n]; lat = cyc - acc;
         end
      end
      if (!got) check($sformatf("u%0d resp timeout", n), vld[n], 1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          lat;
      int          acc_c[3] = '{0, 0, 0};
      int          na = 0;
      bit          accepted;
      bit          seen;
      logic [31:0] got_d[$];

      for (int n = 0; n < 2; n++) begin
         rst[n] = 1'b1; rv[n] = 1'b0; rw[n] = 1'b0;
         ra[n] = 32'h0; rd[n] = 32'h0; rs[n] = 4'h0;
         pend[n] = 1'b0; due[n] = 0; free_at[n] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Reset state, then idle cycles checked by the model.
      @(negedge clk);
      check("reset ready", rdy[0], 1'b1);
      check("reset valid", vld[0], 1'b0);
      check("reset rdata", rdat[0], 32'h0);
      check("reset err", err[0], 1'b0);
      repeat (5) @(posedge clk);
      #1;

      // Store then load, LATENCY=2.
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, lat);
      check("st10 rdata", r, 32'h0);
      check("st10 latency", lat, 2);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, r, e, lat);
      check("ld10 rdata", r, 32'hDEADBEEF);
      check("ld10 latency", lat, 2);

      // Byte strobes.
      do_req(0, 1'b1, 32'h20, 32'h11223344, 4'hF, r, e, lat);
      do_req(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, r, e, lat);
      do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, r, e, lat);
      check("strb0101 rdata", r, 32'h11BB33DD);
      do_req(0, 1'b1, 32'h20, 32'h99999999, 4'b0000, r, e, lat);
      check("strb0000 err", e, 1'b0);
      do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, r, e, lat);
      check("strb0000 rdata", r, 32'h11BB33DD);

      // LATENCY=1: preload three words, then back-to-back loads.
      do_req(1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, r, e, lat);
      check("u1 st latency", lat, 1);
      do_req(1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, r, e, lat);
      do_req(1, 1'b1, 32'h8, 32'hC2C2C2C2, 4'hF, r, e, lat);
      rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h0;
      for (int k = 0; k < 30 && got_d.size() < 3; k++) begin
         @(negedge clk);
         if (vld[1]) got_d.push_back(rdat[1]);
         accepted = rv[1] && rdy[1];
         if (accepted && na < 3) begin
            acc_c[na] = cyc;
            na++;
         end
         @(posedge clk); #1;
         if (accepted) begin
            if (na >= 3) rv[1] = 1'b0;
            else ra[1] = 32'(na * 4);
         end
      end
      rv[1] = 1'b0;
      check("b2b accepts", na, 3);
      check("b2b responses", got_d.size(), 3);
      check("b2b spacing 0-1", acc_c[1] - acc_c[0], 2);
      check("b2b spacing 1-2", acc_c[2] - acc_c[1], 2);
      if (got_d.size() == 3) begin
         check("b2b data0", got_d[0], 32'hA0A0A0A0);
         check("b2b data1", got_d[1], 32'hB1B1B1B1);
         check("b2b data2", got_d[2], 32'hC2C2C2C2);
      end
      @(posedge clk); #1;

      // Reset during WAIT aborts a store.
      do_req(0, 1'b1, 32'h40, 32'h0, 4'hF, r, e, lat);
      rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h40; rd[0] = 32'h12345678; rs[0] = 4'hF;
      for (int k = 0; k < 10 && !rdy[0]; k++) @(negedge clk);
      @(negedge clk);
      check("abort accept ready", rdy[0], 1'b1);
      @(posedge clk); #1;
      rv[0] = 1'b0; rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | vld[0];
      end
      check("abort no resp", seen, 1'b0);
      @(posedge clk); #1;
      do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, r, e, lat);
      check("abort ld40", r, 32'h0);

      // Address checking / wrapping.
      do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, r, e, lat);
`ifdef CPU6_DMEM_ERRCHK_EN
      do_req(0, 1'b0, 32'h42, 32'h0, 4'h0, r, e, lat);
      check("misalign err", e, 1'b1);
      check("misalign rdata", r, 32'h0);
      do_req(0, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, r, e, lat);
      check("oor store err", e, 1'b1);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, r, e, lat);
      check("oor word0 kept", r, 32'hCAFEF00D);
      check("word0 err", e, 1'b0);
`else
      do_req(0, 1'b0, 32'h42, 32'h0, 4'h0, r, e, lat);
      check("misalign ignored err", e, 1'b0);
      check("misalign ignored rdata", r, 32'h0);
      do_req(0, 1'b1, 32'h1000, 32'h55AA55AA, 4'hF, r, e, lat);
      check("wrap store err", e, 1'b0);
      do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, r, e, lat);
      check("wrap word0", r, 32'h55AA55AA);
`endif

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
